// File: rtl/seg7_pkg.sv
// Shared constants and types for the 8-digit multiplexed 7-segment driver.
package seg7_pkg;
  localparam int N_DIGITS = 8;
  localparam int DIGIT_W  = 4;

  typedef logic [6:0] seg_t;  // {g,f,e,d,c,b,a}, high-true

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_DASH  = 7'h40;
  localparam seg_t SEG_BLANK = 7'h00;
endpackage

// File: rtl/seg7_decoder.sv
// BCD nibble to high-true segment pattern; non-decimal nibbles show a dash.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] nibble,
  input  logic               blank,
  output seg_t               seg
);
  always_comb begin
    seg = SEG_DASH;
    if (blank) seg = SEG_BLANK;
    else begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// Double-buffered 8-digit scan driver for a common-segment 7-segment bank.
// Optional leading-zero blanking when SEG7_LEADING_ZERO_BLANK_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] bcd_in,
  input  logic [7:0]  dp_in,
  input  logic        bcd_load,
  output logic [7:0]  an_out,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic        frame_done
);
  localparam int            PW      = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] TC      = PW'(SCAN_DIV - 1);
  localparam seg_t          SEG_INV = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [7:0]    AN_INV  = AN_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic          DP_INV  = SEG_ACTIVE_LOW;

  logic [PW-1:0] prescaler;
  logic [2:0]    idx;
  logic          pending_valid;
  logic [31:0]   shadow_bcd, disp_bcd;
  logic [7:0]    shadow_dp, disp_dp;
  logic          tc, wrap;

  logic [N_DIGITS-1:0]       blank_mask;
  seg_t [N_DIGITS-1:0]       dig_seg;

  assign tc   = enable && (prescaler == TC);
  assign wrap = tc && (idx == 3'(N_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      idx       <= '0;
    end else if (!enable) begin
      prescaler <= '0;
      idx       <= '0;
    end else if (tc) begin
      prescaler <= '0;
      idx       <= idx + 3'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // A load landing on the wrap bypasses the shadow so it shows in the very next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_valid <= 1'b0;
      shadow_bcd    <= '0;
      shadow_dp     <= '0;
      disp_bcd      <= '0;
      disp_dp       <= '0;
    end else if (bcd_load && wrap) begin
      disp_bcd      <= bcd_in;
      disp_dp       <= dp_in;
      shadow_bcd    <= bcd_in;
      shadow_dp     <= dp_in;
      pending_valid <= 1'b0;
    end else if (bcd_load) begin
      shadow_bcd    <= bcd_in;
      shadow_dp     <= dp_in;
      pending_valid <= 1'b1;
    end else if (pending_valid && (wrap || !enable)) begin
      disp_bcd      <= shadow_bcd;
      disp_dp       <= shadow_dp;
      pending_valid <= 1'b0;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic all_zero;
  always_comb begin
    blank_mask = '0;
    all_zero   = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      all_zero      = all_zero && (disp_bcd[k*DIGIT_W +: DIGIT_W] == '0);
      blank_mask[k] = all_zero;
    end
  end
`else
  assign blank_mask = '0;
`endif

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
    seg7_decoder u_dec (
      .nibble (disp_bcd[g*DIGIT_W +: DIGIT_W]),
      .blank  (blank_mask[g]),
      .seg    (dig_seg[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      an_out     <= AN_INV;
      seg_out    <= SEG_INV;
      dp_out     <= DP_INV;
      frame_done <= 1'b0;
    end else begin
      an_out     <= AN_INV ^ (8'(1) << idx);
      seg_out    <= dig_seg[idx] ^ SEG_INV;
      dp_out     <= disp_dp[idx] ^ DP_INV;
      frame_done <= wrap;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed plus randomized bench for seg7_scan_driver against a frame-time model.
module tb_seg7_scan_driver;
  localparam int SD    = 4;
  localparam int FRAME = SD * 8;

  logic        clk = 1'b0;
  logic        rst, enable, bcd_load;
  logic [31:0] bcd_in;
  logic [7:0]  dp_in;
  logic [7:0]  an_out;
  logic [6:0]  seg_out;
  logic        dp_out, frame_done;

  int nchk = 0;
  int nerr = 0;

  seg7_scan_driver #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .bcd_in(bcd_in), .dp_in(dp_in),
    .bcd_load(bcd_load), .an_out(an_out), .seg_out(seg_out), .dp_out(dp_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference: t = cycles since scanning (re)started; slot and wrap follow by division.
  logic [6:0]  tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  int          t = 0;
  bit          m_pend = 0;
  logic [31:0] m_sbcd = '0, m_dbcd = '0;
  logic [7:0]  m_sdp = '0, m_ddp = '0;
  logic [7:0]  e_an = 8'hFF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1, e_fd = 1'b0;

  function automatic logic [6:0] digit_hi(logic [31:0] word, int k);
    logic [31:0] upper;
    logic [3:0]  nib;
    upper = word >> (4 * k);
    nib   = upper[3:0];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (k > 0 && upper == 0) return 7'h00;
`endif
    return tbl[nib];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  slot;
    bit  wrap;
    if (rst) begin
      t = 0; m_pend = 0; m_sbcd = '0; m_dbcd = '0; m_sdp = '0; m_ddp = '0;
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      slot = (t / SD) % 8;
      wrap = enable && (t % FRAME == FRAME - 1);
      if (enable) begin
        e_an  = ~(8'(1) << slot);
        e_seg = ~digit_hi(m_dbcd, slot);
        e_dp  = ~m_ddp[slot];
      end else begin
        e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
      end
      e_fd = wrap;
      if (bcd_load && wrap) begin
        m_dbcd = bcd_in; m_ddp = dp_in; m_pend = 0;
      end else if (bcd_load) begin
        m_sbcd = bcd_in; m_sdp = dp_in; m_pend = 1;
      end else if (m_pend && (wrap || !enable)) begin
        m_dbcd = m_sbcd; m_ddp = m_sdp; m_pend = 0;
      end
      t = enable ? t + 1 : 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("an_out", an_out, e_an);
    chk("seg_out", seg_out, e_seg);
    chk("dp_out", dp_out, e_dp);
    chk("frame_done", frame_done, e_fd);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input logic [31:0] v, input logic [7:0] d);
    bcd_in = v; dp_in = d; bcd_load = 1'b1;
    step();
    bcd_load = 1'b0;
  endtask

  task automatic wait_fd(output int n);
    n = 1;
    step();
    while (frame_done !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("fd_seen", frame_done, 1'b1);
  endtask

  initial begin
    int n;
    rst = 1'b1; enable = 1'b1; bcd_load = 1'b0; bcd_in = '0; dp_in = '0;

    // reset
    step();
    chk("rst_an", an_out, 8'hFF);
    chk("rst_seg", seg_out, 7'h7F);
    chk("rst_dp", dp_out, 1'b1);
    chk("rst_fd", frame_done, 1'b0);
    steps(2);
    rst = 1'b0;

    // basic scan
    load(32'h12345678, 8'h00);
    wait_fd(n);
    step();
    chk("scan_d0_an", an_out, 8'hFE);
    chk("scan_d0_seg", seg_out, 7'h00);
    steps(3);
    chk("scan_d0_hold", seg_out, 7'h00);
    step();
    chk("scan_d1_an", an_out, 8'hFD);
    chk("scan_d1_seg", seg_out, 7'h78);
    wait_fd(n);
    wait_fd(n);
    chk("fd_period", n, FRAME);

    // tear-free update, last write wins
    steps(5);
    load(32'h00000001, 8'h00);
    steps(7);
    load(32'h00000002, 8'h00);
    wait_fd(n);
    step();
    chk("tear_d0", seg_out, 7'h24);

    // load coincident with the wrap edge, invalid nibble
    wait_fd(n);
    steps(FRAME - 1);
    load(32'h0000000A, 8'h00);
    chk("coinc_fd", frame_done, 1'b1);
    step();
    chk("coinc_dash", seg_out, 7'h3F);

    // leading zeros
    load(32'h00000450, 8'h04);
    wait_fd(n);
    steps(9);
    chk("lz_d2_an", an_out, 8'hFB);
    chk("lz_d2_seg", seg_out, 7'h19);
    chk("lz_d2_dp", dp_out, 1'b0);
    steps(20);
    chk("lz_d7_an", an_out, 8'h7F);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    chk("lz_d7_seg", seg_out, 7'h7F);
`else
    chk("lz_d7_seg", seg_out, 7'h40);
`endif
    load(32'h00000000, 8'h00);
    wait_fd(n);
    steps(FRAME);

    // reset mid-frame drops pending load
    wait_fd(n);
    steps(13);
    load(32'h87654321, 8'hFF);
    rst = 1'b1;
    step();
    chk("mid_rst_an", an_out, 8'hFF);
    chk("mid_rst_seg", seg_out, 7'h7F);
    rst = 1'b0;
    steps(2 * FRAME);

    // enable handling
    enable = 1'b0;
    step();
    chk("dis_an", an_out, 8'hFF);
    load(32'h00000099, 8'h01);
    steps(3);
    enable = 1'b1;
    step();
    chk("en_an", an_out, 8'hFE);
    steps(FRAME + 4);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 79) == 0) enable = ~enable;
      bcd_load = ($urandom_range(0, 9) == 0);
      bcd_in   = $urandom() >> $urandom_range(0, 31);
      dp_in    = 8'($urandom());
      step();
    end
    rst = 1'b0; bcd_load = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
